// File: rtl/nibble_serial_adder.sv
// Sequencer that streams WIDTH-bit operands nibble by nibble through an external
// 4-bit adder. It chains the carry through a register and collects the sum nibbles.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_cout,
  output logic             busy
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [IDXW-1:0]   idx;
  logic              carry;
  logic [WIDTH-1:0]  a_reg, b_reg;
  logic [IDXW+1:0]   shamt;
  logic [WIDTH-1:0]  a_shift, b_shift, nib_mask, sum_ins;
  logic              last;

  assign shamt = {idx, 2'b00};
  assign last  = (idx == LAST_IDX);

  // Nibble selection and result-insert masks are shifts by 4*idx.
  always_comb begin
    a_shift  = a_reg >> shamt;
    b_shift  = b_reg >> shamt;
    nib_mask = WIDTH'(4'hF) << shamt;
    sum_ins  = WIDTH'(add_sum) << shamt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    add_a      = 4'h0;
    add_b      = 4'h0;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_shift[3:0];
        add_b   = b_shift[3:0];
        add_cin = carry;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The adder output is registered into the current nibble slot each RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      carry       <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      result      <= '0;
      result_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= op_a;
            b_reg  <= op_b;
            carry  <= op_cin;
            idx    <= '0;
            result <= '0;
          end
        end
        RUN: begin
          result <= (result & ~nib_mask) | sum_ins;
          carry  <= add_cout;
          idx    <= idx + 1'b1;
          if (last) result_cout <= add_cout;
        end
        default: ;
      endcase
    end
  end

endmodule
